// File: rtl/truth_table_sweeper_pkg.sv
// Shared types and constants for the truth-table sweeper.
// State encodings, vector count and a priority-encode helper.
package truth_table_sweeper_pkg;

  localparam int NUM_VECTORS = 8;
  localparam int IDX_W = 3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    SETTLE = 3'd2,
    SAMPLE = 3'd3,
    DONE   = 3'd4
  } state_e;

  function automatic logic [IDX_W-1:0] first_set(
    input logic [NUM_VECTORS-1:0] v
  );
    first_set = '0;
    for (int i = NUM_VECTORS - 1; i >= 0; i--) begin
      if (v[i]) first_set = IDX_W'(i);
    end
  endfunction

endpackage

// File: rtl/truth_table_sweeper_if.sv
// Control/result bundle between a sweep requester and the sweeper.
// master starts sweeps and reads results; slave is the sweeper.
interface truth_table_sweeper_if;

  logic       start;
  logic [7:0] expected;
  logic [7:0] table_out;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] first_fail;

  modport master (
    output start,
    output expected,
    input  table_out,
    input  busy,
    input  done,
    input  pass,
    input  first_fail
  );

  modport slave (
    input  start,
    input  expected,
    output table_out,
    output busy,
    output done,
    output pass,
    output first_fail
  );

endinterface

// File: rtl/truth_table_sweeper_settle_timer.sv
// Settle-time down-counter: load arms it, dec counts down to zero.
// Loaded with SETTLE_CYCLES-1 so zero flags the last settle cycle.
module settle_timer #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic dec,
  output logic zero
);

  localparam logic [7:0] LOAD_VAL =
    (SETTLE_CYCLES > 0) ? 8'(SETTLE_CYCLES - 1) : 8'd0;

  logic [7:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= LOAD_VAL;
    end else if (dec && cnt_q != 8'd0) begin
      cnt_q <= cnt_q - 8'd1;
    end
  end

  assign zero = (cnt_q == 8'd0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives a,b,c through all 8 vectors, captures d into a truth
// table and compares it with a latched expected table.
module truth_table_sweeper
  import truth_table_sweeper_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  truth_table_sweeper_if.slave bus,
  output logic                 a,
  output logic                 b,
  output logic                 c,
  input  logic                 d
);

  state_e state_q, state_d;

  logic [IDX_W-1:0]       idx_q;
  logic [NUM_VECTORS-1:0] exp_q;
  logic [NUM_VECTORS-1:0] table_q;
  logic                   done_q;
  logic                   pass_q;
  logic [IDX_W-1:0]       ff_q;

  logic accept;
  logic do_drive;
  logic do_sample;
  logic timer_load;
  logic timer_dec;
  logic timer_zero;
  logic last;

  assign last = (idx_q == IDX_W'(NUM_VECTORS - 1));

  settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (timer_load),
    .dec   (timer_dec),
    .zero  (timer_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    do_drive   = 1'b0;
    do_sample  = 1'b0;
    timer_load = 1'b0;
    timer_dec  = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        do_drive   = 1'b1;
        timer_load = 1'b1;
        state_d    = (SETTLE_CYCLES > 0) ? SETTLE : SAMPLE;
      end
      SETTLE: begin
        timer_dec = 1'b1;
        if (timer_zero) state_d = SAMPLE;
      end
      SAMPLE: begin
        do_sample = 1'b1;
        state_d   = last ? DONE : DRIVE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Results are registered one cycle after entering DONE, once
  // the last sampled bit is visible in table_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q     <= '0;
      exp_q     <= '0;
      table_q   <= '0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      ff_q      <= '0;
      {a, b, c} <= 3'b000;
    end else begin
      if (accept) begin
        exp_q   <= bus.expected;
        table_q <= '0;
        idx_q   <= '0;
        done_q  <= 1'b0;
        pass_q  <= 1'b0;
        ff_q    <= '0;
      end
      if (do_drive) begin
        {a, b, c} <= idx_q;
      end
      if (do_sample) begin
        table_q[idx_q] <= d;
        if (!last) idx_q <= idx_q + 1'b1;
      end
      if (state_q == DONE && !bus.start) begin
        done_q <= 1'b1;
        pass_q <= (table_q == exp_q);
        ff_q   <= first_set(table_q ^ exp_q);
      end
    end
  end

  assign bus.busy = (state_q == DRIVE) ||
                    (state_q == SETTLE) ||
                    (state_q == SAMPLE);
  assign bus.table_out  = table_q;
  assign bus.done       = done_q;
  assign bus.pass       = pass_q;
  assign bus.first_fail = ff_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: two instances (settle 2 and 0),
// a cycle-level timing model and directed sweeps.
module tb_truth_table_sweeper;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] st;
  logic [7:0] ex [2];
  logic [1:0] fn;
  logic a2, b2, c2, d2;
  logic a0, b0, c0, d0;
  logic [16:0] dout [2];
  logic chk_on = 1'b0;

  int n_pass = 0;
  int n_total = 0;

  truth_table_sweeper_if bus2();
  truth_table_sweeper_if bus0();

  assign bus2.start    = st[0];
  assign bus2.expected = ex[0];
  assign bus0.start    = st[1];
  assign bus0.expected = ex[1];

  assign d2 = fn[0] ? (a2 ^ b2 ^ c2) : (a2 & b2 & c2);
  assign d0 = fn[1] ? (a0 ^ b0 ^ c0) : (a0 & b0 & c0);

  truth_table_sweeper #(.SETTLE_CYCLES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2),
    .a(a2), .b(b2), .c(c2), .d(d2)
  );

  truth_table_sweeper #(.SETTLE_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0),
    .a(a0), .b(b0), .c(c0), .d(d0)
  );

  assign dout[0] = {a2, b2, c2, bus2.table_out, bus2.busy,
                    bus2.done, bus2.pass, bus2.first_fail};
  assign dout[1] = {a0, b0, c0, bus0.table_out, bus0.busy,
                    bus0.done, bus0.pass, bus0.first_fail};

  // Model: edges since accepted start determine every output.
  bit         act [2];
  int         n [2];
  logic [2:0] mabc [2];
  logic [7:0] mtbl [2];
  logic [7:0] mexp [2];

  function automatic int period(input int k);
    return (k == 0) ? 4 : 2;
  endfunction

  function automatic logic [7:0] tt(input logic f);
    logic [7:0] t;
    logic [2:0] v;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      t[i] = f ? ^v : &v;
    end
    return t;
  endfunction

  function automatic logic [2:0] cur_abc(input int k);
    int v;
    if (!act[k] || n[k] == 0) return mabc[k];
    v = (n[k] - 1) / period(k);
    return (v > 7) ? 3'd7 : 3'(v);
  endfunction

  function automatic logic [16:0] model_out(input int k);
    int p;
    logic [7:0] t;
    logic bz, dn, ps;
    logic [2:0] ff;
    p = period(k);
    t = '0; bz = 0; dn = 0; ps = 0; ff = '0;
    if (act[k]) begin
      for (int v = 0; v < 8; v++)
        if ((v + 1) * p <= n[k]) t[v] = mtbl[k][v];
      bz = n[k] < 8 * p;
      dn = n[k] >= 8 * p + 1;
      if (dn) begin
        ps = (mtbl[k] == mexp[k]);
        if (!ps)
          for (int v = 7; v >= 0; v--)
            if (mtbl[k][v] != mexp[k][v]) ff = 3'(v);
      end
    end
    return {cur_abc(k), t, bz, dn, ps, ff};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        act[k] = 0; n[k] = 0; mabc[k] = '0;
        mtbl[k] = '0; mexp[k] = '0;
      end else if (st[k] &&
                   !(act[k] && n[k] < 8 * period(k))) begin
        mabc[k] = cur_abc(k);
        act[k] = 1; n[k] = 0;
        mexp[k] = ex[k];
        mtbl[k] = tt(fn[k]);
      end else if (act[k] && n[k] < 100000) begin
        n[k]++;
      end
    end
  end

  task automatic check(input string name,
                       input logic [31:0] got,
                       input logic [31:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s got %0h want %0h", name, got, want);
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      check("cycle_dut2", 32'(dout[0]), 32'(model_out(0)));
      check("cycle_dut0", 32'(dout[1]), 32'(model_out(1)));
    end
  end

  function automatic logic [7:0] tbl_of(input int k);
    return dout[k][13:6];
  endfunction

  task automatic sweep(input int k, input logic [7:0] e,
                       input logic f, input int pulse_at,
                       input int rst_at, output int edges);
    @(negedge clk);
    fn[k] = f; ex[k] = e; st[k] = 1'b1;
    @(negedge clk);
    st[k] = 1'b0;
    edges = 0;
    while (edges < 200) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      st[k] = 1'b0;
      if (edges == pulse_at) begin
        st[k] = 1'b1; ex[k] = 8'h00;
      end
      if (edges == rst_at) begin
        check("abc_before_rst", 32'(dout[k][16:14]), 32'd5);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_zero", 32'(dout[k]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (dout[k][4]) return;
    end
  endtask

  int e;

  initial begin
    st = '0; fn = '0;
    ex[0] = '0; ex[1] = '0;
    repeat (3) @(negedge clk);
    check("reset_dut2", 32'(dout[0]), 32'd0);
    check("reset_dut0", 32'(dout[1]), 32'd0);
    rst_n = 1'b1;
    chk_on = 1'b1;

    sweep(0, 8'h80, 1'b0, -1, -1, e);
    check("and_edges", e, 33);
    check("and_table", tbl_of(0), 8'h80);
    check("and_pass", dout[0][3], 1);
    check("and_ff", dout[0][2:0], 0);

    sweep(0, 8'h96, 1'b1, -1, -1, e);
    check("xor_edges", e, 33);
    check("xor_table", tbl_of(0), 8'h96);
    check("xor_pass", dout[0][3], 1);
    check("xor_abc_hold", dout[0][16:14], 3'b111);

    sweep(0, 8'h97, 1'b1, -1, -1, e);
    check("x97_pass", dout[0][3], 0);
    check("x97_ff", dout[0][2:0], 0);

    sweep(0, 8'h16, 1'b1, -1, -1, e);
    check("x16_pass", dout[0][3], 0);
    check("x16_ff", dout[0][2:0], 7);

    sweep(0, 8'h96, 1'b1, 14, -1, e);
    check("midstart_edges", e, 33);
    check("midstart_pass", dout[0][3], 1);

    sweep(0, 8'h96, 1'b1, -1, 22, e);
    check("post_rst_dut2", 32'(dout[0]), 32'd0);
    sweep(0, 8'h96, 1'b1, -1, -1, e);
    check("rerun_edges", e, 33);
    check("rerun_table", tbl_of(0), 8'h96);
    check("rerun_pass", dout[0][3], 1);

    sweep(1, 8'h80, 1'b0, -1, -1, e);
    check("s0_edges", e, 17);
    check("s0_table", tbl_of(1), 8'h80);
    check("s0_pass", dout[1][3], 1);

    ex[1] = 8'h81; st[1] = 1'b1;
    @(negedge clk);
    st[1] = 1'b0;
    check("b2b_busy", dout[1][5], 1);
    check("b2b_done_clr", dout[1][4], 0);
    e = 0;
    while (e < 200 && !dout[1][4]) begin
      @(posedge clk);
      e++;
      @(negedge clk);
    end
    check("b2b_edges", e, 17);
    check("b2b_pass", dout[1][3], 0);
    check("b2b_ff", dout[1][2:0], 0);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
